// File: rtl/mem_responder.sv
// Word-addressed memory target: on-chip RAM plus one memory-mapped debug register,
// answering each cpu request after WAIT_STATES programmable wait cycles.
module mem_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [29:0] DBG_ADDR    = 30'h3fffffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         LP_DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    function automatic logic f_in_ram(input logic [29:0] addr);
        return (addr >> ADDR_BITS) == 30'd0;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_capture;
    logic                   r_is_read;
    logic                   r_is_write;
    logic [29:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_busy;
    logic [31:0]            r_dbg;
    logic [31:0]            r_mem [LP_DEPTH];

    logic [29:0]            w_sel_addr;
    logic                   w_sel_read;
    logic                   w_in_ram;
    logic                   w_is_dbg;
    logic                   w_oor;
    logic [ADDR_BITS-1:0]   w_ram_idx;
    logic [31:0]            w_rd_word;
    logic                   w_enter_resp;

    // Next-state and wait counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (re_i || we_i) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // With zero wait states the response is loaded in the sampling cycle, so decode the live request
    always_comb begin
        w_sel_addr = r_addr;
        w_sel_read = r_is_read;
        if (r_state == ST_IDLE) begin
            w_sel_addr = addr_i;
            w_sel_read = re_i;
        end else begin
            w_sel_addr = r_addr;
            w_sel_read = r_is_read;
        end
    end

    // Address decode and read-data source; RAM wins if the debug address aliases into it
    always_comb begin
        w_in_ram     = f_in_ram(w_sel_addr);
        w_is_dbg     = (w_sel_addr == DBG_ADDR);
        w_oor        = !w_in_ram && !w_is_dbg;
        w_ram_idx    = w_sel_addr[ADDR_BITS-1:0];
        w_enter_resp = (w_state_nxt == ST_RESP);
        w_rd_word    = 32'h0000_0000;
        if (w_in_ram) begin
            w_rd_word = r_mem[w_ram_idx];
        end else if (w_is_dbg) begin
            w_rd_word = r_dbg;
        end else begin
            w_rd_word = 32'h0000_0000;
        end
    end

    // Control state, captured request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_is_read  <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= 30'd0;
            r_wdata    <= 32'h0000_0000;
            r_rdata    <= 32'h0000_0000;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_dbg      <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_is_read  <= re_i;
                r_is_write <= we_i && !re_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
            end
            r_ack  <= w_enter_resp;
            r_err  <= w_enter_resp && w_oor;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_enter_resp && w_sel_read) begin
                r_rdata <= w_rd_word;
            end
            if ((r_state == ST_RESP) && r_is_write && w_is_dbg && !w_in_ram) begin
                r_dbg <= r_wdata;
            end
        end
    end

    // RAM write port: commits at the end of RESP, suppressed by reset
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_RESP) && r_is_write && w_in_ram) begin
            r_mem[w_ram_idx] <= r_wdata;
        end
    end

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign busy_o  = r_busy;
    assign dbg_o   = r_dbg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with no wait states, one with three.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        re0, we0, re3, we3;
    logic [29:0] addr0, addr3;
    logic [31:0] wd0, wd3;
    logic [31:0] rd0, rd3, dbg0, dbg3;
    logic        ack0, err0, busy0, ack3, err3, busy3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .DBG_ADDR(30'h3fffffff)) u_ws0 (
        .clk(clk), .rst(rst), .re_i(re0), .we_i(we0), .addr_i(addr0), .wdata_i(wd0),
        .rdata_o(rd0), .ack_o(ack0), .err_o(err0), .busy_o(busy0), .dbg_o(dbg0)
    );

    mem_responder #(.ADDR_BITS(10), .WAIT_STATES(3), .DBG_ADDR(30'h3fffffff)) u_ws3 (
        .clk(clk), .rst(rst), .re_i(re3), .we_i(we3), .addr_i(addr3), .wdata_i(wd3),
        .rdata_o(rd3), .ack_o(ack3), .err_o(err3), .busy_o(busy3), .dbg_o(dbg3)
    );

    function automatic logic f_ack(input int sel);
        return (sel == 0) ? ack0 : ack3;
    endfunction

    function automatic logic f_err(input int sel);
        return (sel == 0) ? err0 : err3;
    endfunction

    function automatic logic f_busy(input int sel);
        return (sel == 0) ? busy0 : busy3;
    endfunction

    function automatic logic [31:0] f_rdata(input int sel);
        return (sel == 0) ? rd0 : rd3;
    endfunction

    function automatic logic [31:0] f_dbg(input int sel);
        return (sel == 0) ? dbg0 : dbg3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic re, input logic we,
                         input logic [29:0] a, input logic [31:0] d);
        if (sel == 0) begin
            re0 = re; we0 = we; addr0 = a; wd0 = d;
        end else begin
            re3 = re; we3 = we; addr3 = a; wd3 = d;
        end
    endtask

    // Issue one request, hold it until ack (bounded), then release and check ack/busy drop.
    task automatic req(input int sel, input logic re, input logic we,
                       input logic [29:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er, output int bc);
        lat = 0;
        bc  = 0;
        rd  = 32'h0000_0000;
        er  = 1'b0;
        drive(sel, re, we, a, d);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (f_busy(sel)) bc++;
            if (f_ack(sel)) begin
                lat = c;
                rd  = f_rdata(sel);
                er  = f_err(sel);
            end
        end
        drive(sel, 1'b0, 1'b0, 30'd0, 32'h0000_0000);
        @(negedge clk);
        chk("ack_pulse", {31'd0, f_ack(sel)}, 32'd0);
        chk("busy_idle", {31'd0, f_busy(sel)}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          bc;
        int          acks;
        logic [31:0] rd;
        logic        er;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 30'd0, 32'h0000_0000);
        drive(3, 1'b0, 1'b0, 30'd0, 32'h0000_0000);
        repeat (2) @(negedge clk);
        for (int s = 0; s <= 3; s += 3) begin
            chk("rst_ack",   {31'd0, f_ack(s)},  32'd0);
            chk("rst_err",   {31'd0, f_err(s)},  32'd0);
            chk("rst_busy",  {31'd0, f_busy(s)}, 32'd0);
            chk("rst_rdata", f_rdata(s),         32'h0000_0000);
            chk("rst_dbg",   f_dbg(s),           32'h0000_0000);
        end
        rst = 1'b0;
        @(negedge clk);

        // zero wait states: write then read back
        req(0, 1'b0, 1'b1, 30'd5, 32'hcafef00d, lat, rd, er, bc);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        chk("ws0_wr_err", {31'd0, er}, 32'd0);
        req(0, 1'b1, 1'b0, 30'd5, 32'h0000_0000, lat, rd, er, bc);
        chk("ws0_rd_lat",   32'(lat), 32'd1);
        chk("ws0_rd_data",  rd, 32'hcafef00d);
        chk("ws0_rd_err",   {31'd0, er}, 32'd0);
        chk("ws0_busy_cnt", 32'(bc), 32'd1);

        req(0, 1'b0, 1'b1, 30'd6, 32'h0000_0066, lat, rd, er, bc);
        chk("wr_keeps_rdata", rd0, 32'hcafef00d);
        req(0, 1'b1, 1'b0, 30'd6, 32'h0000_0000, lat, rd, er, bc);
        chk("rd_after_wr", rd, 32'h0000_0066);

        // out-of-range must not alias onto RAM[0]
        req(0, 1'b0, 1'b1, 30'd0, 32'h0000_a000, lat, rd, er, bc);
        req(0, 1'b0, 1'b1, 30'h400, 32'h1111_1111, lat, rd, er, bc);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_err", {31'd0, er}, 32'd1);
        req(0, 1'b1, 1'b0, 30'd0, 32'h0000_0000, lat, rd, er, bc);
        chk("oor_ram_kept", rd, 32'h0000_a000);
        chk("inrange_err",  {31'd0, er}, 32'd0);
        req(0, 1'b1, 1'b0, 30'h400, 32'h0000_0000, lat, rd, er, bc);
        chk("oor_rd_data", rd, 32'h0000_0000);
        chk("oor_rd_err",  {31'd0, er}, 32'd1);

        // debug register
        req(0, 1'b0, 1'b1, 30'h3fffffff, 32'h1234_5678, lat, rd, er, bc);
        chk("dbg_wr_err", {31'd0, er}, 32'd0);
        chk("dbg_out",    dbg0, 32'h1234_5678);
        req(0, 1'b1, 1'b0, 30'h3fffffff, 32'h0000_0000, lat, rd, er, bc);
        chk("dbg_rd_data", rd, 32'h1234_5678);
        chk("dbg_rd_err",  {31'd0, er}, 32'd0);

        // simultaneous read and write is a read
        req(0, 1'b0, 1'b1, 30'd9, 32'h0000_0909, lat, rd, er, bc);
        req(0, 1'b1, 1'b1, 30'd9, 32'hdeadbeef, lat, rd, er, bc);
        chk("rw_lat",  32'(lat), 32'd1);
        chk("rw_data", rd, 32'h0000_0909);
        chk("rw_err",  {31'd0, er}, 32'd0);
        req(0, 1'b1, 1'b0, 30'd9, 32'h0000_0000, lat, rd, er, bc);
        chk("rw_ram_kept", rd, 32'h0000_0909);

        // three wait states
        req(3, 1'b0, 1'b1, 30'd0, 32'h3333_0000, lat, rd, er, bc);
        chk("ws3_wr_lat", 32'(lat), 32'd4);
        req(3, 1'b1, 1'b0, 30'd0, 32'h0000_0000, lat, rd, er, bc);
        chk("ws3_rd_lat",   32'(lat), 32'd4);
        chk("ws3_busy_cnt", 32'(bc), 32'd4);
        chk("ws3_rd_data",  rd, 32'h3333_0000);

        // reset during WAIT aborts the write
        req(3, 1'b0, 1'b1, 30'd7, 32'ha5a5_0007, lat, rd, er, bc);
        acks = 0;
        drive(3, 1'b0, 1'b1, 30'd7, 32'h0000_0001);
        repeat (2) begin
            @(negedge clk);
            if (ack3) acks++;
        end
        chk("abort_busy_pre", {31'd0, busy3}, 32'd1);
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 30'd0, 32'h0000_0000);
        repeat (2) begin
            @(negedge clk);
            if (ack3) acks++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack3) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_busy",   {31'd0, busy3}, 32'd0);
        req(3, 1'b1, 1'b0, 30'd7, 32'h0000_0000, lat, rd, er, bc);
        chk("abort_lat",      32'(lat), 32'd4);
        chk("abort_old_data", rd, 32'ha5a5_0007);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
